// File: rtl/imem_arbiter_pkg.sv
// Shared constants and types for the instruction-memory front end.
package imem_arbiter_pkg;
    localparam int NUM_SIMD_CORES  = 4;
    localparam int LOG2_IMEM_DEPTH = 8;

    typedef logic [31:0] word_t;

    localparam word_t RET_INSTR = 32'hFFFF_FFFF;
endpackage

// File: rtl/imem_arbiter_if.sv
// Per-core fetch handshake plus the RAM preload port; master = cores/host, slave = arbiter.
interface imem_arbiter_if;
    import imem_arbiter_pkg::*;

    logic  [NUM_SIMD_CORES-1:0] fetch_req;
    word_t [NUM_SIMD_CORES-1:0] instruction_fetch;
    logic  [NUM_SIMD_CORES-1:0] fetch_ack;
    word_t [NUM_SIMD_CORES-1:0] instruction_from_imem;
    logic  [NUM_SIMD_CORES-1:0] instr_valid;
    logic  [NUM_SIMD_CORES-1:0] oor_flag;
    logic                       imem_wr_en;
    logic  [LOG2_IMEM_DEPTH-1:0] imem_wr_addr;
    word_t                      imem_wr_data;

    modport master (
        output fetch_req, instruction_fetch, imem_wr_en, imem_wr_addr, imem_wr_data,
        input  fetch_ack, instruction_from_imem, instr_valid, oor_flag
    );

    modport slave (
        input  fetch_req, instruction_fetch, imem_wr_en, imem_wr_addr, imem_wr_data,
        output fetch_ack, instruction_from_imem, instr_valid, oor_flag
    );
endinterface

// File: rtl/imem_arbiter_rr_arbiter.sv
// N-way round-robin arbiter: grants the first requester after the last winner.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] last_grant;
    logic [IW-1:0] idx;
    logic [IW-1:0] win;
    logic          found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        win   = last_grant;
        idx   = last_grant;
        // Walk N slots starting just after the previous winner.
        for (int i = 0; i < N; i++) begin
            idx = (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        if (en && found) gnt[win] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= IW'(N - 1);
        else if (en && found)
            last_grant <= win;
    end
endmodule

// File: rtl/imem_arbiter.sv
// Round-robin front end sharing one synchronous instruction RAM among the SIMD cores.
// Optional per-core last-fetch hit path enabled by defining IMEM_LAST_HIT_EN.
module imem_arbiter
    import imem_arbiter_pkg::*;
(
    input logic          clk,
    input logic          rst,
    imem_arbiter_if.slave bus
);
    localparam int N  = NUM_SIMD_CORES;
    localparam int AW = LOG2_IMEM_DEPTH;

    word_t mem [2**AW];
    word_t ram_q;

    logic          rst_q, blk, port_en, rd_en;
    logic [AW-1:0] rd_addr;
    logic [N-1:0]  oor, hit, rreq, gnt, ack, vld_q, vld_out, from_ram_q;
    word_t [N-1:0] imm_d, imm_q, hold_q, resp;

    // Acks are blocked during reset and for one cycle after it.
    assign blk     = rst | rst_q;
    assign port_en = ~blk & ~bus.imem_wr_en;
    assign vld_out = vld_q & {N{~rst}};

`ifdef IMEM_LAST_HIT_EN
    word_t [N-1:0] pc_q, tag_pc, tag_data;
    logic  [N-1:0] tag_vld;
`endif

    for (genvar c = 0; c < N; c++) begin : g_core
        assign oor[c] = |bus.instruction_fetch[c][31:AW];
`ifdef IMEM_LAST_HIT_EN
        assign hit[c]   = port_en & bus.fetch_req[c] & tag_vld[c]
                        & (bus.instruction_fetch[c] == tag_pc[c]);
        assign imm_d[c] = hit[c] ? tag_data[c] : RET_INSTR;
`else
        assign hit[c]   = 1'b0;
        assign imm_d[c] = RET_INSTR;
`endif
        assign rreq[c] = bus.fetch_req[c] & ~hit[c];
        assign resp[c] = vld_out[c] ? (from_ram_q[c] ? ram_q : imm_q[c]) : hold_q[c];
    end

    rr_arbiter #(.N(N)) u_rr (
        .clk (clk),
        .rst (rst),
        .req (rreq),
        .en  (port_en),
        .gnt (gnt)
    );

    assign ack   = gnt | hit;
    assign rd_en = |(gnt & ~oor);

    always_comb begin
        rd_addr = '0;
        for (int c = 0; c < N; c++)
            if (gnt[c]) rd_addr = bus.instruction_fetch[c][AW-1:0];
    end

    // Write and read never coincide: a write cycle suppresses all grants.
    always_ff @(posedge clk) begin
        if (bus.imem_wr_en) mem[bus.imem_wr_addr] <= bus.imem_wr_data;
        if (rd_en)          ram_q <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            vld_q      <= '0;
            from_ram_q <= '0;
            imm_q      <= '0;
            hold_q     <= '0;
            bus.oor_flag <= '0;
        end else begin
            vld_q      <= ack;
            from_ram_q <= gnt & ~oor;
            imm_q      <= imm_d;
            hold_q     <= resp;
            bus.oor_flag <= bus.oor_flag | (gnt & oor);
        end
    end

`ifdef IMEM_LAST_HIT_EN
    // Tags fill from RAM responses only; any write or reset drops them all.
    always_ff @(posedge clk) begin
        for (int c = 0; c < N; c++)
            if (gnt[c]) pc_q[c] <= bus.instruction_fetch[c];
        if (rst || bus.imem_wr_en) begin
            tag_vld <= '0;
        end else begin
            for (int c = 0; c < N; c++) begin
                if (vld_q[c] && from_ram_q[c]) begin
                    tag_vld[c]  <= 1'b1;
                    tag_pc[c]   <= pc_q[c];
                    tag_data[c] <= ram_q;
                end
            end
        end
    end
`endif

    assign bus.fetch_ack             = ack;
    assign bus.instr_valid           = vld_out;
    assign bus.instruction_from_imem = resp;
endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter; covers the hit path when IMEM_LAST_HIT_EN is defined.
module tb_imem_arbiter;
    import imem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    imem_arbiter_if bus();

    imem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        bus.imem_wr_en   = 1'b1;
        bus.imem_wr_addr = a;
        bus.imem_wr_data = d;
        tick();
        bus.imem_wr_en   = 1'b0;
    endtask

    task automatic set_pcs(input logic [31:0] p0, input logic [31:0] p1,
                           input logic [31:0] p2, input logic [31:0] p3);
        bus.instruction_fetch[0] = p0;
        bus.instruction_fetch[1] = p1;
        bus.instruction_fetch[2] = p2;
        bus.instruction_fetch[3] = p3;
    endtask

    initial begin
        rst = 1'b1;
        bus.fetch_req    = '0;
        bus.imem_wr_en   = 1'b0;
        bus.imem_wr_addr = '0;
        bus.imem_wr_data = '0;
        set_pcs(32'h0E, 32'h21, 32'h01, 32'h10);
        tick();
        tick();
        rst = 1'b0;
        settle();
        check("reset_ack",   32'(bus.fetch_ack),   32'h0);
        check("reset_valid", 32'(bus.instr_valid), 32'h0);
        check("reset_data0", bus.instruction_from_imem[0], 32'h0);
        check("reset_oor",   32'(bus.oor_flag),    32'h0);
        tick();

        wr(8'h0E, 32'hAABF_F000);
        wr(8'h21, 32'hAAA0_3000);
        wr(8'h01, 32'h1111_0001);
        wr(8'h10, 32'h2222_0010);

        // All four request at once: ascending grants from core 0.
        bus.fetch_req = 4'b1111;
        settle();
        check("all_ack0", 32'(bus.fetch_ack), 32'h1);
        tick();
        bus.fetch_req = 4'b1110;
        settle();
        check("c0_valid", 32'(bus.instr_valid), 32'h1);
        check("c0_data",  bus.instruction_from_imem[0], 32'hAABF_F000);
        check("all_ack1", 32'(bus.fetch_ack), 32'h2);
        tick();
        bus.fetch_req = 4'b1100;
        settle();
        check("c1_data",  bus.instruction_from_imem[1], 32'hAAA0_3000);
        check("all_ack2", 32'(bus.fetch_ack), 32'h4);
        tick();
        bus.fetch_req = 4'b1000;
        settle();
        check("c2_data",  bus.instruction_from_imem[2], 32'h1111_0001);
        check("all_ack3", 32'(bus.fetch_ack), 32'h8);
        tick();
        bus.fetch_req = 4'b0000;
        settle();
        check("c3_valid", 32'(bus.instr_valid), 32'h8);
        check("c3_data",  bus.instruction_from_imem[3], 32'h2222_0010);
        check("c0_hold",  bus.instruction_from_imem[0], 32'hAABF_F000);
        check("idle_ack", 32'(bus.fetch_ack), 32'h0);
        tick();
        settle();
        check("valid_pulse", 32'(bus.instr_valid), 32'h0);
        tick();

        // Cores 3 and 0 together after last grant = 3.
        bus.fetch_req = 4'b1001;
        settle();
`ifdef IMEM_LAST_HIT_EN
        check("rr_wrap_hit", 32'(bus.fetch_ack), 32'h9);
        tick();
        bus.fetch_req = 4'b0000;
        settle();
        check("rr_wrap_hit_vld", 32'(bus.instr_valid), 32'h9);
        check("rr_wrap_hit_d0",  bus.instruction_from_imem[0], 32'hAABF_F000);
`else
        check("rr_wrap", 32'(bus.fetch_ack), 32'h1);
        tick();
        bus.fetch_req = 4'b1000;
        settle();
        check("rr_wrap_next", 32'(bus.fetch_ack), 32'h8);
        tick();
        bus.fetch_req = 4'b0000;
        settle();
        check("rr_wrap_vld", 32'(bus.instr_valid), 32'h8);
`endif
        tick();

        // Two write cycles stall core 1; the write to its PC wins.
        bus.fetch_req    = 4'b0010;
        bus.imem_wr_en   = 1'b1;
        bus.imem_wr_addr = 8'h21;
        bus.imem_wr_data = 32'h5555_AAAA;
        settle();
        check("wr_block0", 32'(bus.fetch_ack), 32'h0);
        tick();
        settle();
        check("wr_block1", 32'(bus.fetch_ack), 32'h0);
        tick();
        bus.imem_wr_en = 1'b0;
        settle();
        check("wr_after_ack", 32'(bus.fetch_ack), 32'h2);
        tick();
        bus.fetch_req = 4'b0000;
        settle();
        check("wr_new_data", bus.instruction_from_imem[1], 32'h5555_AAAA);
        tick();

        // Out-of-range PC on core 2.
        bus.instruction_fetch[2] = 32'hABCD_EF01;
        bus.fetch_req = 4'b0100;
        settle();
        check("oor_ack", 32'(bus.fetch_ack), 32'h4);
        tick();
        bus.fetch_req = 4'b0000;
        bus.instruction_fetch[2] = 32'h01;
        settle();
        check("oor_valid", 32'(bus.instr_valid), 32'h4);
        check("oor_data",  bus.instruction_from_imem[2], 32'hFFFF_FFFF);
        check("oor_flag",  32'(bus.oor_flag), 32'h4);
        tick();
        tick();
        settle();
        check("oor_sticky", 32'(bus.oor_flag), 32'h4);
        tick();

        // Reset right after an ack kills the response and restores priority.
        bus.fetch_req = 4'b0001;
        settle();
        check("pre_rst_ack", 32'(bus.fetch_ack), 32'h1);
        tick();
        rst = 1'b1;
        bus.fetch_req = 4'b0000;
        settle();
        check("rst_no_valid", 32'(bus.instr_valid), 32'h0);
        tick();
        rst = 1'b0;
        bus.fetch_req = 4'b1001;
        settle();
        check("post_rst_ack",   32'(bus.fetch_ack),   32'h0);
        check("post_rst_valid", 32'(bus.instr_valid), 32'h0);
        check("post_rst_d0",    bus.instruction_from_imem[0], 32'h0);
        check("post_rst_d2",    bus.instruction_from_imem[2], 32'h0);
        check("post_rst_oor",   32'(bus.oor_flag),    32'h0);
        tick();
        settle();
        check("post_rst_prio", 32'(bus.fetch_ack), 32'h1);
        tick();
        bus.fetch_req = 4'b1000;
        settle();
        check("post_rst_d0_new", bus.instruction_from_imem[0], 32'hAABF_F000);
        check("post_rst_ack3",   32'(bus.fetch_ack), 32'h8);
        tick();
        bus.fetch_req = 4'b0000;
        settle();
        check("post_rst_d3", bus.instruction_from_imem[3], 32'h2222_0010);
        tick();

`ifdef IMEM_LAST_HIT_EN
        // Core 0 tag hit alongside a RAM grant to core 1.
        bus.fetch_req = 4'b0001;
        settle();
        check("hit_first", 32'(bus.fetch_ack), 32'h1);
        tick();
        bus.fetch_req = 4'b0000;
        tick();
        bus.fetch_req = 4'b0011;
        settle();
        check("hit_same_cycle", 32'(bus.fetch_ack), 32'h3);
        tick();
        bus.fetch_req = 4'b0000;
        settle();
        check("hit_vld",   32'(bus.instr_valid), 32'h3);
        check("hit_data0", bus.instruction_from_imem[0], 32'hAABF_F000);
        check("hit_data1", bus.instruction_from_imem[1], 32'h5555_AAAA);
        tick();
        wr(8'h50, 32'h0BAD_0BAD);
        bus.fetch_req = 4'b0101;
        settle();
        check("inval_no_hit", 32'(bus.fetch_ack), 32'h4);
        tick();
        bus.fetch_req = 4'b0001;
        settle();
        check("inval_ram_ack", 32'(bus.fetch_ack), 32'h1);
        tick();
        bus.fetch_req = 4'b0000;
        settle();
        check("inval_data0", bus.instruction_from_imem[0], 32'hAABF_F000);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
